afifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag stage of the async FIFO. Accepts push requests and drives the RAM write address and enable. Produces the registered gray-coded write pointer that feeds the read-domain 2-FF synchronizer. Consumes the read pointer, already gray-coded and synchronized into this domain, to compute full, overflow and (optionally) fill level.

---
 rtl/afifo_wptr_full.sv | 121 ++++++++++++
 tb/tb_afifo_wptr_full.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wptr_full.sv
// afifo_wptr_full
// ---------------
// Write-domain half of an asynchronous FIFO. It owns the binary write
// pointer, publishes a registered gray copy of it for the read-domain
// synchronizer, drives the RAM write port, and compares against the
// already-synchronized gray read pointer to produce a registered full flag
// and a sticky overflow flag.
//
// Optional build macro: AFIFO_WLEVEL_EN
//   When defined, the synchronized read pointer is also converted to binary
//   to produce a registered fill level (wlevel_o) and almost-full flag
//   (almost_full_o). When undefined those ports and that logic are absent.
//
// Ports:
//   clk_i            write-domain clock
//   rst_i            synchronous, active-high reset
//   push_i           write request
//   rptr_gray_sync_i read pointer, gray, synchronized into clk_i domain
//   wptr_gray_o      write pointer, gray, straight from a flop
//   waddr_o          RAM write address (low ADDR_WIDTH bits of binary ptr)
//   wen_o            RAM write enable = push_i & ~full_o
//   full_o           FIFO full (registered)
//   overflow_o       sticky: push attempted while full
//   wlevel_o         fill level 0..DEPTH (AFIFO_WLEVEL_EN only)
//   almost_full_o    level >= DEPTH - AF_MARGIN (AFIFO_WLEVEL_EN only)
//
// Handshake: push_i is a request and ~full_o is the ready. A write happens
// on a clock edge exactly when wen_o (= push_i & ~full_o) is high; a push
// seen while full_o is high is dropped and latches overflow_o.

module afifo_wptr_full #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync_i,
    output logic [ADDR_WIDTH:0]   wptr_gray_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic                  wen_o,
    output logic                  full_o,
    output logic                  overflow_o
`ifdef AFIFO_WLEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wlevel_o,
    output logic                  almost_full_o
`endif
);

    localparam int A = ADDR_WIDTH;

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] full_match;
    logic       full_next;

    assign wen_o   = push_i & ~full_o;
    assign waddr_o = wbin[A-1:0];

    assign wbin_next  = wbin + {{A{1'b0}}, wen_o};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // In gray code, "write is exactly one lap ahead of read" means the top
    // two bits differ and the rest match. Staying in the gray domain avoids
    // any conversion of the synchronized pointer on the full path.
    assign full_match = {~rptr_gray_sync_i[A:A-1], rptr_gray_sync_i[A-2:0]};
    assign full_next  = (wgray_next == full_match);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin        <= '0;
            wptr_gray_o <= '0;
            full_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray_o <= wgray_next;
            full_o      <= full_next;
            overflow_o  <= overflow_o | (push_i & full_o);
        end
    end

`ifdef AFIFO_WLEVEL_EN
    localparam logic [A:0] DEPTH     = (A+1)'(1 << A);
    localparam logic [A:0] AF_THRESH = (A+1)'((1 << A) - AF_MARGIN);

    logic [A:0] rbin;
    logic [A:0] wlevel_next;
    logic       almost_full_next;

    // Gray to binary: each binary bit is the XOR of all gray bits at and
    // above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++) begin
            rbin[i] = ^(rptr_gray_sync_i >> i);
        end
    end

    // The read pointer is stale by the synchronizer latency, so this can
    // only over-report occupancy.
    assign wlevel_next      = wbin_next - rbin;
    assign almost_full_next = (wlevel_next >= AF_THRESH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wlevel_o      <= '0;
            almost_full_o <= 1'b0;
        end else begin
            wlevel_o      <= wlevel_next;
            almost_full_o <= almost_full_next;
        end
    end

    logic unused_depth;
    assign unused_depth = ^DEPTH;
`endif

endmodule

// File: tb/tb_afifo_wptr_full.sv
// tb_afifo_wptr_full
// ------------------
// Directed bench for afifo_wptr_full with ADDR_WIDTH=4, AF_MARGIN=2.
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled 1 time unit after the edge, wen_o 1 time unit after inputs change.

module tb_afifo_wptr_full;

    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          push;
    logic [AW:0]   rptr;
    logic [AW:0]   wptr_gray;
    logic [AW-1:0] waddr;
    logic          wen;
    logic          full;
    logic          overflow;
`ifdef AFIFO_WLEVEL_EN
    logic [AW:0]   wlevel;
    logic          almost_full;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [AW:0] exp_q[$];

    afifo_wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .push_i           (push),
        .rptr_gray_sync_i (rptr),
        .wptr_gray_o      (wptr_gray),
        .waddr_o          (waddr),
        .wen_o            (wen),
        .full_o           (full),
        .overflow_o       (overflow)
`ifdef AFIFO_WLEVEL_EN
        ,
        .wlevel_o         (wlevel),
        .almost_full_o    (almost_full)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        push = 1'b0;
        rptr = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gray"},  32'(wptr_gray), 32'd0);
        check({tag, " waddr"}, 32'(waddr),     32'd0);
        check({tag, " full"},  32'(full),      32'd0);
        check({tag, " ovf"},   32'(overflow),  32'd0);
        check({tag, " wen"},   32'(wen),       32'(push));
`ifdef AFIFO_WLEVEL_EN
        check({tag, " wlevel"}, 32'(wlevel),      32'd0);
        check({tag, " af"},     32'(almost_full), 32'd0);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        push;
        logic [AW:0] rptr;
        logic        exp_wen;
        logic [3:0]  exp_waddr;
        logic [AW:0] exp_gray;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[20];

    // gray codes of 1..16, written out by hand
    logic [AW:0] gray_lut[16] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                  5'b00111, 5'b00101, 5'b00100, 5'b01100,
                                  5'b01101, 5'b01111, 5'b01110, 5'b01010,
                                  5'b01011, 5'b01001, 5'b01000, 5'b11000};

    task automatic drive_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        push = v.push;
        rptr = v.rptr;
        #1;
        check($sformatf("v%0d wen", idx), 32'(wen), 32'(v.exp_wen));
        @(posedge clk);
        #1;
        check($sformatf("v%0d waddr", idx), 32'(waddr),     32'(v.exp_waddr));
        check($sformatf("v%0d gray", idx),  32'(wptr_gray), 32'(v.exp_gray));
        check($sformatf("v%0d full", idx),  32'(full),      32'(v.exp_full));
        check($sformatf("v%0d ovf", idx),   32'(overflow),  32'(v.exp_ovf));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Fill from empty: 16 accepted pushes
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 5'b00000, 1'b1, 4'((i + 1) % 16), gray_lut[i], (i == 15), 1'b0};
        // Push while full: dropped, overflow latches
        vecs[16] = '{1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1};
        // Push released: overflow stays
        vecs[17] = '{1'b0, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1};
        // Reader advances one entry: full drops one cycle later
        vecs[18] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1};
        // One push refills
        vecs[19] = '{1'b1, 5'b00001, 1'b1, 4'd1, 5'b11001, 1'b1, 1'b1};

        // Reset then idle
        do_reset();
        check_all_zero("rst");
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all_zero($sformatf("idle%0d", i));
        end

        // Table-driven fill / overflow / drain-by-one
        for (int i = 0; i < 20; i++) drive_vec(i);

        // Reset mid-stream while full with overflow set and push held
        rst  = 1'b1;
        push = 1'b1;
        tick();
        rst  = 1'b0;
        push = 1'b0;
        rptr = '0;
        #1;
        check_all_zero("midrst");

        // Wrap: 100 pushes, read pointer follows 3 cycles behind
        begin
            logic [AW:0] mbin;
            logic [AW:0] hist[$];
            logic [AW:0] prev;
            logic [AW:0] g;
            mbin = '0;
            prev = wptr_gray;
            hist = '{5'b0, 5'b0, 5'b0};
            for (int c = 0; c < 100; c++) begin
                push = 1'b1;
                rptr = hist.pop_front();
                mbin = mbin + 1'b1;
                g = mbin ^ (mbin >> 1);
                exp_q.push_back(g);
                tick();
                check($sformatf("wrap%0d gray", c), 32'(wptr_gray), 32'(exp_q.pop_front()));
                check($sformatf("wrap%0d hd", c), 32'($countones(prev ^ wptr_gray) <= 1), 32'd1);
                check($sformatf("wrap%0d full", c), 32'(full), 32'd0);
                check($sformatf("wrap%0d ovf", c), 32'(overflow), 32'd0);
                if (c == 31) check("wrap32 zero", 32'(wptr_gray), 32'd0);
                prev = wptr_gray;
                hist.push_back(wptr_gray);
            end
            push = 1'b0;
            check("wrap end waddr", 32'(waddr), 32'd4);
            check("wrap end gray", 32'(wptr_gray), 32'b00110);
        end

`ifdef AFIFO_WLEVEL_EN
        // Level / almost-full
        do_reset();
        for (int i = 0; i < 14; i++) begin
            push = 1'b1;
            tick();
            if (i == 12) begin
                check("lvl13", 32'(wlevel), 32'd13);
                check("af13", 32'(almost_full), 32'd0);
            end
        end
        push = 1'b0;
        check("lvl14", 32'(wlevel), 32'd14);
        check("af14", 32'(almost_full), 32'd1);
        rptr = 5'b00111;
        tick();
        check("lvl9", 32'(wlevel), 32'd9);
        check("af9", 32'(almost_full), 32'd0);
`endif

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
